audio_adc_deserializer: RTL and testbench

- Receive-side counterpart of the audio DAC serializer inside audio_interface.
- Captures the codec ADC bitstream (AUD_ADCDAT, framed by AUD_BCLK and AUD_ADCLRCK, codec is clock master) in the CLOCK_50 domain.
- Deserializes left-justified stereo words and buffers left/right pairs in a small first-word-fall-through FIFO.
- Presents pairs to the sequencer over a valid/ready handshake.

---
 rtl/audio_adc_deserializer_if.sv | 33 +++
 rtl/audio_adc_deserializer.sv | 174 +++++++++++++++++
 tb/tb_audio_adc_deserializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_adc_deserializer_if.sv
// rtl/audio_adc_deserializer_if.sv - stereo sample pair handshake between ADC deserializer and consumer
// mono_data is present only when ADC_MONO_MIX_EN is defined.
interface audio_adc_deserializer_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] left_data;
    logic [DATA_WIDTH-1:0] right_data;
    logic                  sample_valid;
    logic                  sample_ready;
`ifdef ADC_MONO_MIX_EN
    logic [DATA_WIDTH-1:0] mono_data;
`endif

    modport master (
        output left_data,
        output right_data,
        output sample_valid,
`ifdef ADC_MONO_MIX_EN
        output mono_data,
`endif
        input  sample_ready
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  sample_valid,
`ifdef ADC_MONO_MIX_EN
        input  mono_data,
`endif
        output sample_ready
    );
endinterface

// File: rtl/audio_adc_deserializer.sv
// rtl/audio_adc_deserializer.sv - codec ADC left-justified stereo capture into a FWFT pair FIFO
// Optional ADC_MONO_MIX_EN adds a combinational mono mix of the FIFO head.
module audio_adc_deserializer #(
    parameter int DATA_WIDTH  = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_ADCLRCK,
    input  logic                          AUD_ADCDAT,
    audio_adc_deserializer_if.master      smp,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic                          short_frame
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {ST_ALIGN, ST_SHIFT, ST_HOLD} state_t;

    state_t                 r_state, w_state_next;
    logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrck_sync, r_dat_sync;
    logic                   r_bclk_d, r_lrck_d;
    logic                   w_bclk_rise, w_lrck_edge, w_lrck_lvl, w_dat;
    logic [DATA_WIDTH-1:0]  r_shift, w_shift_next, r_left_hold, r_right_hold;
    logic [CW-1:0]          r_count;
    logic                   r_chan, r_left_valid, r_push, r_short, r_overflow;
    logic                   w_start, w_shift_en, w_latch;
    logic [DATA_WIDTH-1:0]  r_mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  r_mem_r [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [AW:0]            r_level;
    logic                   w_full, w_pop, w_wr;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_d    <= 1'b0;
            r_lrck_d    <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
            r_bclk_d    <= r_bclk_sync[SYNC_STAGES-1];
            r_lrck_d    <= r_lrck_sync[SYNC_STAGES-1];
        end
    end

    assign w_bclk_rise = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_d;
    assign w_lrck_lvl  = r_lrck_sync[SYNC_STAGES-1];
    assign w_lrck_edge = w_lrck_lvl ^ r_lrck_d;
    assign w_dat       = r_dat_sync[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= ST_ALIGN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ALIGN: if (w_lrck_edge && w_lrck_lvl) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_lrck_edge || (w_bclk_rise && r_count == LAST_BIT)) w_state_next = ST_HOLD;
            ST_HOLD:  if (w_lrck_lvl != r_chan) w_state_next = ST_SHIFT;
            default:  w_state_next = ST_ALIGN;
        endcase
    end

    // HOLD restarts as soon as LRCK disagrees with the captured channel, which
    // also covers the edge that ended the word early.
    always_comb begin
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_latch    = 1'b0;
        case (r_state)
            ST_ALIGN: w_start = w_lrck_edge && w_lrck_lvl;
            ST_SHIFT: begin
                w_shift_en = w_bclk_rise && !w_lrck_edge;
                w_latch    = w_lrck_edge || (w_bclk_rise && r_count == LAST_BIT);
            end
            ST_HOLD:  w_start = (w_lrck_lvl != r_chan);
            default:  ;
        endcase
    end

    // Bits land at their final MSB-first position, so a short word is already left-aligned.
    always_comb begin
        w_shift_next = r_shift;
        if (w_shift_en) w_shift_next[LAST_BIT - r_count] = w_dat;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_count      <= '0;
            r_chan       <= 1'b0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_left_valid <= 1'b0;
            r_push       <= 1'b0;
            r_short      <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (w_start) begin
                r_shift <= '0;
                r_count <= '0;
                r_chan  <= w_lrck_lvl;
            end else if (w_shift_en) begin
                r_shift <= w_shift_next;
                r_count <= r_count + 1'b1;
            end
            if (w_latch) begin
                if (r_chan) begin
                    r_left_hold  <= w_shift_next;
                    r_left_valid <= 1'b1;
                end else begin
                    r_right_hold <= w_shift_next;
                    r_push       <= r_left_valid;
                    r_left_valid <= 1'b0;
                end
            end
            if (w_latch && w_lrck_edge) r_short <= 1'b1;
            else if (clear_overflow)    r_short <= 1'b0;
        end
    end

    assign w_full = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_pop  = smp.sample_valid && smp.sample_ready;
    assign w_wr   = r_push && (!w_full || w_pop);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_l[i] <= '0;
                r_mem_r[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem_l[r_wr_ptr] <= r_left_hold;
                r_mem_r[r_wr_ptr] <= r_right_hold;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_wr && w_pop) r_level <= r_level - 1'b1;
            if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (clear_overflow)        r_overflow <= 1'b0;
        end
    end

    assign smp.sample_valid = (r_level != '0);
    assign smp.left_data    = r_mem_l[r_rd_ptr];
    assign smp.right_data   = r_mem_r[r_rd_ptr];
    assign fifo_level       = r_level;
    assign overflow         = r_overflow;
    assign short_frame      = r_short;

`ifdef ADC_MONO_MIX_EN
    logic signed [DATA_WIDTH:0] w_mono_sum;
    assign w_mono_sum    = $signed({r_mem_l[r_rd_ptr][DATA_WIDTH-1], r_mem_l[r_rd_ptr]})
                         + $signed({r_mem_r[r_rd_ptr][DATA_WIDTH-1], r_mem_r[r_rd_ptr]});
    assign smp.mono_data = DATA_WIDTH'(w_mono_sum >>> 1);
`endif
endmodule

// File: tb/tb_audio_adc_deserializer.sv
// tb/tb_audio_adc_deserializer.sv - scoreboard bench for audio_adc_deserializer
// Honours ADC_MONO_MIX_EN when defined.
`timescale 1ns/1ps
module tb_audio_adc_deserializer;
    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;
    localparam int BCLKS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk = 1'b0, lrck = 1'b0, dat = 1'b0, clear = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic ovf, shortf;

    audio_adc_deserializer_if #(.DATA_WIDTH(DW)) smp();

    audio_adc_deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .CLOCK_50       (clk),
        .reset          (rst),
        .AUD_BCLK       (bclk),
        .AUD_ADCLRCK    (lrck),
        .AUD_ADCDAT     (dat),
        .smp            (smp),
        .fifo_level     (level),
        .overflow       (ovf),
        .clear_overflow (clear),
        .short_frame    (shortf)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q_l[$];
    logic [DW-1:0] q_r[$];
    bit exp_ovf = 1'b0;
    bit rand_ready = 1'b0;
    logic [DW-1:0] cur_left_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        if (q_l.size() >= DEPTH) exp_ovf = 1'b1;
        else begin
            q_l.push_back(l);
            q_r.push_back(r);
        end
    endtask

    always @(negedge clk) if (rand_ready) smp.sample_ready = ($urandom_range(0, 3) == 0);

    // Scoreboard: expected pairs queue up at their push edge and are retired on handshakes.
    initial begin
`ifdef ADC_MONO_MIX_EN
        int a, b, m;
`endif
        smp.sample_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            chk("fifo_level", 64'(level), 64'(q_l.size()));
            chk("sample_valid", 64'(smp.sample_valid), 64'(q_l.size() != 0));
            chk("overflow", 64'(ovf), 64'(exp_ovf));
            if (smp.sample_valid && q_l.size() != 0) begin
                chk("left_data", 64'(smp.left_data), 64'(q_l[0]));
                chk("right_data", 64'(smp.right_data), 64'(q_r[0]));
`ifdef ADC_MONO_MIX_EN
                a = $signed(q_l[0]);
                b = $signed(q_r[0]);
                m = (a + b) >>> 1;
                chk("mono_data", 64'(smp.mono_data), 64'(m[DW-1:0]));
`endif
                if (smp.sample_ready) begin
                    void'(q_l.pop_front());
                    void'(q_r.pop_front());
                end
            end
        end
    end

    // Codec side: LRCK and data change on BCLK falling edges, MSB first.
    task automatic send_channel(input bit lvl, input logic [DW-1:0] word, input int nbits,
                                input int nbclk, input bit push, input bit pulse);
        for (int i = 0; i < nbclk; i++) begin
            bclk = 1'b0;
            if (i == 0) lrck = lvl;
            dat = (i < nbits) ? word[DW-1-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            bclk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (i == DW - 1) begin
                    if (pulse && k == SYNC + 1) smp.sample_ready = 1'b1;
                    if (pulse && k == SYNC + 2) smp.sample_ready = 1'b0;
                    if (push && k == SYNC + 2) model_push(cur_left_exp, word);
                end
            end
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int lbits,
                              input bit push, input bit pulse);
        logic [DW-1:0] mask;
        mask = '1;
        mask = mask << (DW - lbits);
        cur_left_exp = l & mask;
        send_channel(1'b1, l, lbits, (lbits < DW) ? lbits : BCLKS, 1'b0, 1'b0);
        send_channel(1'b0, r, DW, BCLKS, push, pulse);
    endtask

    task automatic drain();
        int n;
        n = 0;
        smp.sample_ready = 1'b1;
        while (q_l.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q_l.size()), 64'd0);
        smp.sample_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_left_data", 64'(smp.left_data), 64'd0);
        chk("reset_short_frame", 64'(shortf), 64'd0);
        rst = 1'b0;

        send_frame(24'h123456, 24'hABCDEF, DW, 1'b1, 1'b0);
        chk("basic_level", 64'(level), 64'd1);
        chk("basic_short", 64'(shortf), 64'd0);
        drain();

        rand_ready = 1'b1;
        repeat (10) send_frame(DW'($urandom), DW'($urandom), DW, 1'b1, 1'b0);
        rand_ready = 1'b0;
        smp.sample_ready = 1'b0;
        drain();
        pulse_clear();

        // Reset mid right word with LRCK low; the partial word must never appear.
        send_frame(DW'($urandom), DW'($urandom), DW, 1'b1, 1'b0);
        send_channel(1'b1, DW'($urandom), DW, BCLKS, 1'b0, 1'b0);
        send_channel(1'b0, DW'($urandom), DW, 10, 1'b0, 1'b0);
        rst = 1'b1;
        q_l.delete();
        q_r.delete();
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_level", 64'(level), 64'd0);
        rst = 1'b0;
        send_channel(1'b0, DW'($urandom), DW, 22, 1'b0, 1'b0);
        send_frame(24'h5A5A5A, 24'h0F0F0F, DW, 1'b1, 1'b0);
        chk("align_level", 64'(level), 64'd1);
        drain();

        for (int f = 0; f < 5; f++) send_frame(DW'($urandom), DW'($urandom), DW, 1'b1, 1'b0);
        chk("ovf_level", 64'(level), 64'd4);
        chk("ovf_set", 64'(ovf), 64'd1);
        pulse_clear();
        @(negedge clk);
        chk("ovf_cleared", 64'(ovf), 64'd0);

        send_frame(24'h111111, 24'h222222, DW, 1'b1, 1'b1);
        chk("fullpop_level", 64'(level), 64'd4);
        chk("fullpop_ovf", 64'(ovf), 64'd0);
        drain();

        send_frame(24'hFFFFF0, 24'h333333, 20, 1'b1, 1'b0);
        chk("short_set", 64'(shortf), 64'd1);
        chk("short_left", 64'(smp.left_data), 64'hFFFFF0);
        drain();
        pulse_clear();
        @(negedge clk);
        chk("short_cleared", 64'(shortf), 64'd0);

        send_frame(24'h7FFFFF, 24'h7FFFFF, DW, 1'b1, 1'b0);
        send_frame(24'h800000, 24'h000000, DW, 1'b1, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
